alu_control_mdu: RTL and testbench

- Second-generation ALU control for the MIPS datapath.
- Keeps the 4-bit `op` / 6-bit `funct` to 4-bit ALU `control` decode, parametrised in data width.
- Adds an iterative multiply/divide unit (MDU) with HI/LO registers and a pipeline stall output.
- Sits in EX beside the ALU. The EX result mux picks `mdu_result` when `mdu_sel` is high.

---
 rtl/alu_control_mdu.sv | 145 ++++++++++++++
 tb/tb_alu_control_mdu.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_control_mdu.sv
// alu_control_mdu: MIPS ALU control decode plus iterative mult/div unit with HI/LO and stall; ports clk, rst_n (sync active-low), valid/op/funct/a/b in, control/mdu_sel/mdu_result/stall (comb), busy/hi/lo (registered); define ALU_CONTROL_MDU_DIV_EN to build div/divu
module alu_control_mdu #(
  parameter int WIDTH = 32,
  parameter int OP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [OP_W-1:0]  op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       control,
  output logic             mdu_sel,
  output logic [WIDTH-1:0] mdu_result,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] p, nxt, prod;
  logic [WIDTH-1:0] m, aa, ba;
  logic [WIDTH:0] sum;
  logic [3:0] rctl;
  logic neg_p, is_r, f_mult, f_multu, f_div, f_divu, f_mfhi, f_mthi, f_mflo, f_mtlo;
  logic sgn, start, mdu_op, issue;
  assign is_r    = op == OP_W'(2);
  assign f_mult  = is_r && funct == 6'b011000;
  assign f_multu = is_r && funct == 6'b011001;
  assign f_mfhi  = is_r && funct == 6'b010000;
  assign f_mthi  = is_r && funct == 6'b010001;
  assign f_mflo  = is_r && funct == 6'b010010;
  assign f_mtlo  = is_r && funct == 6'b010011;
`ifdef ALU_CONTROL_MDU_DIV_EN
  logic is_div, neg_r;
  logic [WIDTH:0] sh, diff;
  assign f_div  = is_r && funct == 6'b011010;
  assign f_divu = is_r && funct == 6'b011011;
  assign sh     = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign diff   = sh - {1'b0, m};
  assign nxt    = is_div ? (diff[WIDTH] ? {sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                        : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1})
                         : {sum, p[WIDTH-1:1]};
`else
  assign f_div  = 1'b0;
  assign f_divu = 1'b0;
  assign nxt    = {sum, p[WIDTH-1:1]};
`endif
  assign sgn        = f_mult | f_div;
  assign start      = f_mult | f_multu | f_div | f_divu;
  assign mdu_op     = start | f_mfhi | f_mthi | f_mflo | f_mtlo;
  assign busy       = state != IDLE;
  assign stall      = valid & mdu_op & busy;
  assign issue      = valid & mdu_op & ~busy;
  assign mdu_sel    = valid & (f_mfhi | f_mflo) & ~stall;
  assign mdu_result = f_mfhi ? hi : lo;
  // Signed ops run on magnitudes; signs are reapplied in FIX.
  assign aa   = (sgn && a[WIDTH-1]) ? -a : a;
  assign ba   = (sgn && b[WIDTH-1]) ? -b : b;
  assign sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
  assign prod = neg_p ? -p : p;
  always_comb begin
    rctl = funct == 6'b100000 ? 4'b0010 :
           funct == 6'b100010 ? 4'b0110 :
           funct == 6'b100101 ? 4'b0001 :
           funct == 6'b101010 ? 4'b0111 :
           funct == 6'b100111 ? 4'b1100 : 4'b0000;
    control = op == OP_W'(0) ? 4'b0010 :
              op == OP_W'(1) ? 4'b0110 :
              op == OP_W'(4) ? 4'b0100 :
              op == OP_W'(5) ? 4'b0001 :
              op == OP_W'(6) ? 4'b0111 :
              is_r           ? rctl    : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      p     <= '0;
      m     <= '0;
      neg_p <= 1'b0;
`ifdef ALU_CONTROL_MDU_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (issue) begin
          if (f_mthi) hi <= a;
          if (f_mtlo) lo <= a;
          cnt   <= CW'(WIDTH - 1);
          neg_p <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          if (f_mult | f_multu) begin
            p     <= {{WIDTH{1'b0}}, ba};
            m     <= aa;
            state <= RUN;
`ifdef ALU_CONTROL_MDU_DIV_EN
            is_div <= 1'b0;
`endif
          end
`ifdef ALU_CONTROL_MDU_DIV_EN
          if (f_div | f_divu) begin
            is_div <= 1'b1;
            neg_r  <= sgn & a[WIDTH-1];
            p      <= {{WIDTH{1'b0}}, aa};
            m      <= ba;
            state  <= RUN;
            // Divide by zero skips iteration; FIX passes p through unsigned.
            if (b == '0) begin
              p     <= {a, {WIDTH{1'b1}}};
              neg_p <= 1'b0;
              neg_r <= 1'b0;
              state <= FIX;
            end
          end
`endif
        end
        RUN: begin
          p   <= nxt;
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
`ifdef ALU_CONTROL_MDU_DIV_EN
          if (is_div) begin
            lo <= neg_p ? -p[WIDTH-1:0] : p[WIDTH-1:0];
            hi <= neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
          end else
            {hi, lo} <= prod;
`else
          {hi, lo} <= prod;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_control_mdu.sv
// tb_alu_control_mdu: directed scoreboard bench for alu_control_mdu at WIDTH=32
module tb_alu_control_mdu;
  logic clk, rst_n, valid, mdu_sel, stall, busy;
  logic [3:0] op, control;
  logic [5:0] funct;
  logic [31:0] a, b, mdu_result, hi, lo;
  logic [63:0] sb[$];
  logic [63:0] e;
  int vecs = 0, errs = 0;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [13:0] tbl [18] = '{
    {4'd0, 6'b000000, 4'b0010}, {4'd1, 6'b000000, 4'b0110}, {4'd3, 6'b100010, 4'b0000},
    {4'd4, 6'b000000, 4'b0100}, {4'd5, 6'b000000, 4'b0001}, {4'd6, 6'b000000, 4'b0111},
    {4'd2, 6'b100000, 4'b0010}, {4'd2, 6'b100010, 4'b0110}, {4'd2, 6'b100100, 4'b0000},
    {4'd2, 6'b100101, 4'b0001}, {4'd2, 6'b101010, 4'b0111}, {4'd2, 6'b100111, 4'b1100},
    {4'd2, 6'b000000, 4'b0000}, {4'd2, 6'b011000, 4'b0000}, {4'd2, 6'b011011, 4'b0000},
    {4'd2, 6'b010000, 4'b0000}, {4'd7, 6'b100000, 4'b0000}, {4'd15, 6'b000000, 4'b0000}};

  alu_control_mdu dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .op(op), .funct(funct), .a(a), .b(b),
    .control(control), .mdu_sel(mdu_sel), .mdu_result(mdu_result), .stall(stall),
    .busy(busy), .hi(hi), .lo(lo));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sp;
    if (f == MULT) begin
      sp = longint'($signed(x)) * longint'($signed(y));
      return sp;
    end
    if (f == MULTU) return {32'b0, x} * {32'b0, y};
    if (y == 0) return {x, 32'hFFFFFFFF};
    if (f == DIVU) return {x % y, x / y};
    if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    return {32'($signed(x) % $signed(y)), 32'($signed(x) / $signed(y))};
  endfunction

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] x,
                        input logic [31:0] y, input int lat);
    int n;
    valid = 1; op = 4'd2; funct = f; a = x; b = y;
    #1 chk({tag, "_issue_stall"}, {63'b0, stall}, 64'd0);
    sb.push_back(model(f, x, y));
    step();
    valid = 0;
    chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_hilo"}, {hi, lo}, sb.pop_front());
  endtask

  initial begin
    rst_n = 0; valid = 0; op = 0; funct = 0; a = 0; b = 0;
    step();
    step();
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1;
    for (int i = 0; i < 18; i++) begin
      op = tbl[i][13:10];
      funct = tbl[i][9:4];
      #1;
      chk($sformatf("decode_%0d", i), {60'b0, control}, {60'b0, tbl[i][3:0]});
      chk($sformatf("decode_stall_%0d", i), {63'b0, stall}, 64'd0);
    end
    step();
    valid = 1; op = 4'd2; funct = MTHI; a = 32'h12345678;
    step();
    funct = MTLO; a = 32'h9ABCDEF0;
    step();
    chk("mthi_mtlo", {hi, lo}, 64'h12345678_9ABCDEF0);
    funct = MFHI;
    #1 chk("mfhi", {31'b0, mdu_sel, mdu_result}, {31'b0, 1'b1, 32'h12345678});
    funct = MFLO;
    #1 chk("mflo", {31'b0, mdu_sel, mdu_result}, {31'b0, 1'b1, 32'h9ABCDEF0});
    funct = 6'b100000;
    #1 chk("add_nosel", {63'b0, mdu_sel}, 64'd0);
    step();
`ifndef ALU_CONTROL_MDU_DIV_EN
    funct = DIV; a = 5; b = 0;
    #1 chk("nodiv_stall", {59'b0, stall, control}, 64'd0);
    step();
    funct = DIVU;
    step();
    chk("nodiv_busy", {63'b0, busy}, 64'd0);
    chk("nodiv_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
`endif
    valid = 0;
    run_op("smul", MULT, 32'hFFFFFFFD, 32'd7, 33);
    chk("smul_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op("umul", MULTU, 32'hFFFFFFFF, 32'd2, 33);
    chk("umul_const", {hi, lo}, 64'h00000001_FFFFFFFE);
    run_op("smul_mm", MULT, 32'h80000000, 32'h80000000, 33);
    for (int i = 0; i < 4; i++)
      run_op($sformatf("rmul_%0d", i), i[0] ? MULTU : MULT, $urandom, $urandom, 33);
`ifdef ALU_CONTROL_MDU_DIV_EN
    run_op("sdiv", DIV, 32'hFFFFFFF9, 32'd2, 33);
    chk("sdiv_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("div0", DIV, 32'd5, 32'd0, 1);
    chk("div0_const", {hi, lo}, 64'h00000005_FFFFFFFF);
    run_op("sdiv_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 33);
    chk("sdiv_ovf_const", {hi, lo}, 64'h00000000_80000000);
    run_op("sdiv_pos_neg", DIV, 32'd100, 32'hFFFFFFF9, 33);
    run_op("udiv_big", DIVU, 32'hFFFFFFFF, 32'h80000001, 33);
    for (int i = 0; i < 3; i++)
      run_op($sformatf("rdiv_%0d", i), i[0] ? DIVU : DIV, $urandom, $urandom_range(1, 32'hFFFF), 33);
`endif
    begin
      int n, s;
      valid = 1; op = 4'd2; funct = MULT; a = 32'h00012345; b = 32'hFFF00000;
      sb.push_back(model(MULT, a, b));
      step();
      funct = MFHI;
      n = 0; s = 0;
      while (busy === 1'b1 && n < 100) begin
        #1 if (stall === 1'b1) s++;
        step();
        n++;
      end
      chk("hazard_stall_cycles", 64'(s), 64'd33);
      e = sb.pop_front();
      #1 chk("hazard_unstalled", {62'b0, stall, mdu_sel}, 64'd1);
      chk("hazard_mfhi", {32'b0, mdu_result}, {32'b0, e[63:32]});
      chk("hazard_lo", {32'b0, lo}, {32'b0, e[31:0]});
      step();
      valid = 0;
    end
    valid = 1; op = 4'd2; a = 32'hFFFFFFF9; b = 32'd2;
`ifdef ALU_CONTROL_MDU_DIV_EN
    funct = DIV;
`else
    funct = MULT;
`endif
    step();
    valid = 0;
    repeat (9) step();
    rst_n = 0;
    step();
    rst_n = 1;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    run_op("post_rst", MULT, 32'd6, 32'd7, 33);
    chk("post_rst_const", {hi, lo}, 64'd42);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
